// File: rtl/fusion_sched.sv
// Dual-sensor fusion scheduler: pops optical/thermal line buffers in lockstep and
// generates frame sync, pixel valid, frame status and an underrun watchdog.
module fusion_sched #(
  parameter int unsigned H_W    = 12,
  parameter int unsigned V_W    = 11,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned TO_W   = 16
) (
  input  logic           iclk,
  input  logic           rst_i,
  input  logic           enable,
  input  logic [H_W-1:0] cfg_h_active,
  input  logic [H_W-1:0] cfg_h_blank,
  input  logic [V_W-1:0] cfg_v_active,
  input  logic [V_W-1:0] cfg_v_blank,
  input  logic           o_line_rdy,
  input  logic           t_line_rdy,
  output logic           o_rd_en,
  output logic           t_rd_en,
  output logic           fus_sync,
  output logic           fus_valid,
  output logic [V_W-1:0] line_cnt,
  output logic           busy,
  output logic           frame_done,
  output logic           err_underrun,
  input  logic           err_clr
);

  localparam int unsigned CW = (H_W > V_W) ? H_W : V_W;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_WAIT, S_ACTIVE, S_HBLANK, S_VBLANK
  } state_t;

  state_t            state;
  logic [H_W-1:0]    h_act;
  logic [H_W-1:0]    h_blk;
  logic [V_W-1:0]    v_act;
  logic [V_W-1:0]    v_blk;
  logic [CW-1:0]     cnt;
  logic [TO_W-1:0]   wd;
  logic              rd_en;
  logic              sync_int;
  logic [RD_LAT-1:0] vpipe;
  logic [RD_LAT-1:0] spipe;

  logic              both_rdy_c;
  logic              h_last_c;
  logic              hb_last_c;
  logic              vb_last_c;
  logic              vb_pen_c;
  logic              last_line_c;
  logic [TO_W-1:0]   wd_inc_c;

  // Terminal-count decodes against the per-frame shadow geometry
  always_comb begin
    both_rdy_c  = o_line_rdy & t_line_rdy;
    h_last_c    = (cnt == CW'(h_act - H_W'(1)));
    hb_last_c   = (cnt == CW'(h_blk - H_W'(1)));
    vb_last_c   = (cnt == CW'(v_blk - V_W'(1)));
    vb_pen_c    = ((cnt + CW'(2)) == CW'(v_blk));
    last_line_c = (line_cnt == (v_act - V_W'(1)));
    wd_inc_c    = (wd == '1) ? wd : (wd + TO_W'(1));
  end

  always_ff @(posedge iclk) begin
    if (rst_i) begin
      state        <= S_IDLE;
      h_act        <= '0;
      h_blk        <= '0;
      v_act        <= '0;
      v_blk        <= '0;
      cnt          <= '0;
      wd           <= '0;
      line_cnt     <= '0;
      rd_en        <= 1'b0;
      sync_int     <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      err_underrun <= 1'b0;
      vpipe        <= '0;
      spipe        <= '0;
    end else begin
      rd_en      <= 1'b0;
      sync_int   <= 1'b0;
      frame_done <= 1'b0;
      vpipe      <= RD_LAT'({vpipe, rd_en});
      spipe      <= RD_LAT'({spipe, sync_int});

      // Watchdog saturates; setting wins over a simultaneous clear
      wd <= (state == S_WAIT && !both_rdy_c) ? wd_inc_c : '0;
      if (state == S_WAIT && wd_inc_c == '1) begin
        err_underrun <= 1'b1;
      end else if (err_clr) begin
        err_underrun <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (enable) begin
            state    <= S_SYNC;
            sync_int <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_SYNC: begin
          h_act    <= (cfg_h_active == '0) ? H_W'(1) : cfg_h_active;
          h_blk    <= cfg_h_blank;
          v_act    <= (cfg_v_active == '0) ? V_W'(1) : cfg_v_active;
          v_blk    <= (cfg_v_blank == '0) ? V_W'(1) : cfg_v_blank;
          line_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (both_rdy_c) begin
            state <= S_ACTIVE;
            cnt   <= '0;
            rd_en <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (h_last_c) begin
            cnt <= '0;
            if (last_line_c) begin
              state      <= S_VBLANK;
              frame_done <= (v_blk == V_W'(1));
            end else begin
              line_cnt <= line_cnt + V_W'(1);
              state    <= (h_blk == '0) ? S_WAIT : S_HBLANK;
            end
          end else begin
            cnt   <= cnt + CW'(1);
            rd_en <= 1'b1;
          end
        end
        S_HBLANK: begin
          if (hb_last_c) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_VBLANK: begin
          if (vb_last_c) begin
            cnt <= '0;
            if (enable) begin
              state    <= S_SYNC;
              sync_int <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt        <= cnt + CW'(1);
            frame_done <= vb_pen_c;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_rd_en   = rd_en;
  assign t_rd_en   = rd_en;
  assign fus_valid = vpipe[RD_LAT-1];
  assign fus_sync  = spipe[RD_LAT-1];

endmodule

// File: tb/tb_fusion_sched.sv
// Bench for fusion_sched: per-cycle stimulus tables replayed into the DUT and
// checked against a frame-walking reference timeline plus directed spot checks.
module tb_fusion_sched;

  localparam int unsigned H_W    = 12;
  localparam int unsigned V_W    = 11;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned TO_W   = 4;
  localparam int MAXC   = 2048;
  localparam int WD_MAX = (1 << TO_W) - 1;

  logic           iclk = 1'b0;
  logic           rst_i = 1'b1;
  logic           enable = 1'b0;
  logic [H_W-1:0] cfg_h_active = '0;
  logic [H_W-1:0] cfg_h_blank = '0;
  logic [V_W-1:0] cfg_v_active = '0;
  logic [V_W-1:0] cfg_v_blank = '0;
  logic           o_line_rdy = 1'b0;
  logic           t_line_rdy = 1'b0;
  logic           err_clr = 1'b0;
  logic           o_rd_en, t_rd_en, fus_sync, fus_valid, busy, frame_done, err_underrun;
  logic [V_W-1:0] line_cnt;

  always #5 iclk = ~iclk;

  fusion_sched #(.H_W(H_W), .V_W(V_W), .RD_LAT(RD_LAT), .TO_W(TO_W)) dut (
    .iclk(iclk), .rst_i(rst_i), .enable(enable),
    .cfg_h_active(cfg_h_active), .cfg_h_blank(cfg_h_blank),
    .cfg_v_active(cfg_v_active), .cfg_v_blank(cfg_v_blank),
    .o_line_rdy(o_line_rdy), .t_line_rdy(t_line_rdy),
    .o_rd_en(o_rd_en), .t_rd_en(t_rd_en), .fus_sync(fus_sync), .fus_valid(fus_valid),
    .line_cnt(line_cnt), .busy(busy), .frame_done(frame_done),
    .err_underrun(err_underrun), .err_clr(err_clr)
  );

  // Stimulus tables, indexed by cycle since the last reset
  bit st_en [MAXC];
  bit st_ro [MAXC];
  bit st_rt [MAXC];
  bit st_clr[MAXC];
  int st_ha [MAXC];
  int st_hb [MAXC];
  int st_va [MAXC];
  int st_vb [MAXC];

  // Expected timeline
  bit ex_rd  [MAXC];
  bit ex_sync[MAXC];
  bit ex_fd  [MAXC];
  bit ex_busy[MAXC];
  bit ex_err [MAXC];
  int ex_line[MAXC];
  int ex_wk  [MAXC];

  // Observed values kept for spot checks
  bit ob_rd  [MAXC];
  bit ob_fv  [MAXC];
  bit ob_fs  [MAXC];
  bit ob_fd  [MAXC];
  bit ob_busy[MAXC];
  bit ob_err [MAXC];
  int ob_line[MAXC];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      st_en[i] = 1'b0; st_ro[i] = 1'b1; st_rt[i] = 1'b1; st_clr[i] = 1'b0;
      st_ha[i] = 4; st_hb[i] = 2; st_va[i] = 3; st_vb[i] = 5;
    end
  endtask

  // Walk frames line by line from the geometry rules, recording each cycle's outputs
  task automatic model(input int n);
    int t, lc, ha, hb, va, vb, k;
    bit go, again;
    t = 0; lc = 0;
    for (int i = 0; i < MAXC; i++) begin
      ex_rd[i] = 0; ex_sync[i] = 0; ex_fd[i] = 0; ex_busy[i] = 0;
      ex_err[i] = 0; ex_line[i] = 0; ex_wk[i] = 0;
    end
    while (t <= n) begin
      ex_line[t] = lc;
      if (!st_en[t]) begin
        t++;
        continue;
      end
      t++;
      do begin
        ha = (st_ha[t] == 0) ? 1 : st_ha[t];
        hb = st_hb[t];
        va = (st_va[t] == 0) ? 1 : st_va[t];
        vb = (st_vb[t] == 0) ? 1 : st_vb[t];
        ex_busy[t] = 1; ex_sync[t] = 1; ex_line[t] = lc;
        lc = 0;
        t++;
        for (int l = 0; l < va; l++) begin
          k = 0;
          do begin
            k++;
            ex_busy[t] = 1; ex_line[t] = lc; ex_wk[t] = k;
            go = st_ro[t] && st_rt[t];
            t++;
          end while (!go && t < MAXC - 64);
          for (int p = 0; p < ha; p++) begin
            ex_busy[t] = 1; ex_rd[t] = 1; ex_line[t] = lc;
            t++;
          end
          if (l != va - 1) begin
            lc++;
            for (int b = 0; b < hb; b++) begin
              ex_busy[t] = 1; ex_line[t] = lc;
              t++;
            end
          end
        end
        again = 0;
        for (int b = 0; b < vb; b++) begin
          ex_busy[t] = 1; ex_line[t] = lc;
          if (b == vb - 1) begin
            ex_fd[t] = 1;
            again = st_en[t];
          end
          t++;
        end
      end while (again && t < MAXC - 64);
    end
    for (int i = 0; i < MAXC - 1; i++)
      ex_err[i+1] = (ex_wk[i] >= WD_MAX) ? 1'b1 : (st_clr[i] ? 1'b0 : ex_err[i]);
  endtask

  task automatic drive(input int t);
    rst_i        = 1'b0;
    enable       = st_en[t];
    o_line_rdy   = st_ro[t];
    t_line_rdy   = st_rt[t];
    err_clr      = st_clr[t];
    cfg_h_active = H_W'(st_ha[t]);
    cfg_h_blank  = H_W'(st_hb[t]);
    cfg_v_active = V_W'(st_va[t]);
    cfg_v_blank  = V_W'(st_vb[t]);
  endtask

  // Replay cycles 0..n-1, check cycle n as well, and reset during cycle n
  task automatic run_scn(input int n);
    int fv_exp, fs_exp;
    model(n);
    for (int t = 0; t <= n; t++) begin
      @(negedge iclk);
      cyc = t;
      fv_exp = (t >= int'(RD_LAT)) ? int'(ex_rd[t-int'(RD_LAT)]) : 0;
      fs_exp = (t >= int'(RD_LAT)) ? int'(ex_sync[t-int'(RD_LAT)]) : 0;
      chk("o_rd_en",      int'(o_rd_en),      int'(ex_rd[t]));
      chk("t_rd_en",      int'(t_rd_en),      int'(ex_rd[t]));
      chk("fus_valid",    int'(fus_valid),    fv_exp);
      chk("fus_sync",     int'(fus_sync),     fs_exp);
      chk("busy",         int'(busy),         int'(ex_busy[t]));
      chk("frame_done",   int'(frame_done),   int'(ex_fd[t]));
      chk("line_cnt",     int'(line_cnt),     ex_line[t]);
      chk("err_underrun", int'(err_underrun), int'(ex_err[t]));
      ob_rd[t] = o_rd_en; ob_fv[t] = fus_valid; ob_fs[t] = fus_sync; ob_fd[t] = frame_done;
      ob_busy[t] = busy; ob_err[t] = err_underrun; ob_line[t] = int'(line_cnt);
      drive(t);
      if (t == n) rst_i = 1'b1;
    end
  endtask

  task automatic rand_scn(input int n);
    int ha, hb, va, vb, p_rdy;
    bit en;
    clear_stim();
    p_rdy = $urandom_range(1, 4);
    ha = $urandom_range(0, 6); hb = $urandom_range(0, 3);
    va = $urandom_range(0, 3); vb = $urandom_range(0, 4);
    en = 1'b1;
    for (int t = 0; t < n; t++) begin
      if ($urandom_range(0, 39) == 0) begin
        ha = $urandom_range(0, 6); hb = $urandom_range(0, 3);
        va = $urandom_range(0, 3); vb = $urandom_range(0, 4);
      end
      if ($urandom_range(0, 59) == 0) en = ~en;
      st_en[t]  = en;
      st_ro[t]  = ($urandom_range(0, 3) < p_rdy);
      st_rt[t]  = ($urandom_range(0, 3) < p_rdy);
      st_clr[t] = ($urandom_range(0, 19) == 0);
      st_ha[t] = ha; st_hb[t] = hb; st_va[t] = va; st_vb[t] = vb;
    end
  endtask

  initial begin
    repeat (2) @(negedge iclk);

    // Nominal frame, all buffers ready
    clear_stim();
    for (int t = 0; t < 30; t++) st_en[t] = 1'b1;
    run_scn(30);
    chk("s1_sync_c1", int'(ob_fs[1]), 0);
    chk("s1_sync_c2", int'(ob_fs[2]), 1);
    chk("s1_rd_c3", int'(ob_rd[3]), 1);
    chk("s1_rd_c6", int'(ob_rd[6]), 1);
    chk("s1_rd_c7", int'(ob_rd[7]), 0);
    chk("s1_rd_c10", int'(ob_rd[10]), 1);
    chk("s1_rd_c20", int'(ob_rd[20]), 1);
    chk("s1_fv_c21", int'(ob_fv[21]), 1);
    chk("s1_fd_c24", int'(ob_fd[24]), 0);
    chk("s1_fd_c25", int'(ob_fd[25]), 1);
    chk("s1_resync_c27", int'(ob_fs[27]), 1);

    // Thermal buffer late for the first line
    clear_stim();
    for (int t = 0; t < 30; t++) begin
      st_en[t] = 1'b1;
      st_rt[t] = (t >= 8);
    end
    run_scn(30);
    chk("s2_rd_c8", int'(ob_rd[8]), 0);
    chk("s2_rd_c9", int'(ob_rd[9]), 1);
    chk("s2_rd_c12", int'(ob_rd[12]), 1);
    chk("s2_rd_c13", int'(ob_rd[13]), 0);

    // Underrun watchdog: saturate, clear ignored while starving, clear after data
    clear_stim();
    for (int t = 0; t < 50; t++) begin
      st_en[t] = 1'b1;
      st_ro[t] = (t >= 40);
      st_rt[t] = (t >= 40);
    end
    st_clr[25] = 1'b1;
    st_clr[43] = 1'b1;
    run_scn(50);
    chk("s3_err_c16", int'(ob_err[16]), 0);
    chk("s3_err_c17", int'(ob_err[17]), 1);
    chk("s3_err_c26", int'(ob_err[26]), 1);
    chk("s3_rd_c41", int'(ob_rd[41]), 1);
    chk("s3_err_c43", int'(ob_err[43]), 1);
    chk("s3_err_c44", int'(ob_err[44]), 0);

    // Enable dropped during line 1: frame completes then idles
    clear_stim();
    for (int t = 0; t < 8; t++) st_en[t] = 1'b1;
    run_scn(40);
    chk("s4_fd_c25", int'(ob_fd[25]), 1);
    chk("s4_busy_c25", int'(ob_busy[25]), 1);
    chk("s4_busy_c26", int'(ob_busy[26]), 0);
    chk("s4_sync_c27", int'(ob_fs[27]), 0);
    chk("s4_rd_c30", int'(ob_rd[30]), 0);

    // Geometry change mid-frame applies only from the next frame; zero h_blank
    clear_stim();
    for (int t = 0; t < 30; t++) st_en[t] = 1'b1;
    for (int t = 5; t < MAXC; t++) begin
      st_ha[t] = 8;
      st_hb[t] = 0;
    end
    run_scn(80);
    chk("s5_rd_c6", int'(ob_rd[6]), 1);
    chk("s5_rd_c7", int'(ob_rd[7]), 0);
    chk("s5_rd_c35", int'(ob_rd[35]), 1);
    chk("s5_rd_c36", int'(ob_rd[36]), 0);
    chk("s5_rd_c37", int'(ob_rd[37]), 1);

    // Reset lands in ACTIVE of line 1
    clear_stim();
    for (int t = 0; t < 30; t++) st_en[t] = 1'b1;
    run_scn(11);
    chk("s6_line_c11", ob_line[11], 1);
    chk("s6_rd_c11", int'(ob_rd[11]), 1);

    // Clean restart after that reset
    clear_stim();
    for (int t = 0; t < 30; t++) st_en[t] = 1'b1;
    run_scn(30);
    chk("s7_rd_c0", int'(ob_rd[0]), 0);
    chk("s7_fv_c0", int'(ob_fv[0]), 0);
    chk("s7_busy_c0", int'(ob_busy[0]), 0);
    chk("s7_line_c0", ob_line[0], 0);
    chk("s7_sync_c2", int'(ob_fs[2]), 1);
    chk("s7_fd_c25", int'(ob_fd[25]), 1);

    for (int r = 0; r < 5; r++) begin
      rand_scn(300);
      run_scn(300);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
